mii_rx_checker: RTL and testbench
=================================

# mii_rx_checker

Receive-side counterpart of the 64-bit MII frame generator. It accepts the 64-bit data plus 8-bit per-lane control stream (start 0xFB, terminate 0xFD, idle 0x07), checks the start word and preamble/SFD, and strips all control characters. It delivers frame bytes, from destination address through FCS, as registered beats with SOP/EOP/keep, and reports length and error status per frame. It sits between the MII generator/loopback and the MAC-side checker agents.

## Interface
- `PAYLOAD_MAX_SIZE`, 1500: largest legal payload in bytes; maximum frame = PAYLOAD_MAX_SIZE+18.
- `MIN_FRAME_LEN`, 64: smallest legal frame in bytes (DA through FCS).
- `clk` in 1: single clock; all logic on rising edge.
- `i_rst` in 1: synchronous reset, active-high.
- `i_valid` in 1: input word qualifier; when low, the input is ignored and all state is held.
- `i_mii_rx_d` in 64: lane k = bits [8k+7:8k]; lane 0 is first on the wire.
- `i_mii_rx_c` in 8: bit k = 1 marks lane k as a control character.
- `o_valid` out 1: output beat valid; no backpressure.
- `o_data` out 64: frame bytes, lane 0 first.
- `o_keep` out 8: valid lanes; contiguous from lane 0.
- `o_sop` out 1: first beat of a frame.
- `o_eop` out 1: last beat of a frame.
- `o_err` out 1: valid with `o_eop`; frame is bad.
- `o_len` out 16: frame byte count; valid with `o_eop`.
- `o_good_cnt` out 32: good-frame counter (see Configuration).
- `o_bad_cnt` out 32: bad-frame and preamble-error counter (see Configuration).

## Operation
- States: IDLE, DATA.
- IDLE
  - Start word: c=0x01, lane0=0xFB, lanes1–6=0x55, lane7=0xD5 → DATA, clear the length counter, set a pending-SOP flag.
  - Start word with a bad preamble or SFD → stay in IDLE, count as bad, emit nothing.
  - Any other word, including 0xFB in lanes 1–7, is ignored.
- DATA, all-data word (c=0x00)
  - If the hold register H is full, emit H with eop=0.
  - Load H with the new word, keep=0xFF; length += 8.
- DATA, terminate word: lowest control lane k holds 0xFD, lanes <k are data, lanes >k are 0x07 control.
  - k=0: emit H with eop=1.
  - k>0: emit H with eop=0 if full, then load H with lanes <k, keep=(1<<k)-1, and set pending-EOP. H is emitted with eop=1 on the next accepted cycle, independent of the input word.
  - Length += k; go to IDLE.
- DATA, any other control pattern (0xFE, 0xFB, a non-idle character after 0xFD, or 0xFD preceded by a control lane): emit H with eop=1, err=1; go to IDLE. The rest of that frame is ignored.
- Terminate at lane 0 directly after the start word: emit one beat with keep=0x00, sop=1, eop=1, len=0, err=1.
- `o_err` = protocol error OR len < MIN_FRAME_LEN OR len > PAYLOAD_MAX_SIZE+18.
- Length arithmetic is 16-bit and saturates at 0xFFFF.
- Back-to-back frames: a start word may arrive in the cycle after the terminate word. The pending-EOP beat is emitted in that cycle while the new start word is checked. The start word produces no data, so there is no output collision.

## Timing
- All outputs are registered.
- Reset: every output is 0, state = IDLE, H empty, counters = 0.
- Latency: a data word accepted at edge n appears on the outputs after the edge of the next accepted word (n+1 at full rate). The final partial beat appears one accepted cycle after the terminate word.
- `o_sop` is asserted on the first emitted beat after the start word.
- `o_len` and `o_err` are valid only when `o_eop`=1.
- A cycle with `i_valid`=0 produces `o_valid`=0 and changes no state.
- Reset mid-frame: outputs are zero on the next cycle, no EOP is generated, and the frame is discarded.

## Configuration
- `MII_RX_STATS_EN`
  - Defined: `o_good_cnt` increments once per frame ending with eop=1 and err=0. `o_bad_cnt` increments once per frame ending with err=1 and once per rejected start word. Both are 32-bit, wrap, and clear on reset.
  - Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- 64-byte frame: start word, 8 data words, terminate at lane 0 followed by idles → 8 beats, sop on beat 1, eop on beat 8, keep=0xFF, len=64, err=0, good_cnt=1.
- 65-byte frame: terminate at lane 1 (c=0xFE) → 9 beats, last beat keep=0x01, len=65, err=0.
- Runt 60-byte frame: terminate at lane 4 after 7 data words → last beat keep=0x0F, len=60, err=1, bad_cnt=1.
- Start word with lane7=0xD4 followed by data words → no `o_valid`, state stays IDLE, bad_cnt=1.
- 0xFE with c=0x08 in the 3rd data word → eop=1, err=1 on the beat holding the 2nd word; remaining words produce no output until the next valid start word.
- `i_rst`=1 in the middle of a 1518-byte frame → all outputs 0 on the next cycle, no eop. A following 64-byte frame is received correctly.

Source files
------------

// File: rtl/mii_rx_checker.sv
// 64-bit MII receive checker: validates start/preamble, strips control characters
// and emits frame beats with SOP/EOP/keep, length and error status.
// Optional per-frame statistics counters are built when MII_RX_STATS_EN is defined.
module mii_rx_checker #(
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int MIN_FRAME_LEN    = 64
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [63:0] i_mii_rx_d,
    input  logic [7:0]  i_mii_rx_c,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic [7:0]  o_keep,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_err,
    output logic [15:0] o_len,
    output logic [31:0] o_good_cnt,
    output logic [31:0] o_bad_cnt
);

    // state | meaning
    // IDLE  | waiting for a start word; flushes a pending final beat
    // DATA  | inside a frame, collecting words into the hold register
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [15:0] LEN_MIN    = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] LEN_MAX    = 16'(PAYLOAD_MAX_SIZE + 18);

    state_t      state;
    logic [63:0] h_data;
    logic [7:0]  h_keep;
    logic        h_full;
    logic        sop_pend;
    logic        eop_pend;
    logic [15:0] len_cnt;

    logic        is_start;
    logic        pre_ok;
    logic        is_data;
    logic [2:0]  term_k;
    logic        term_ok;
    logic [7:0]  part_keep;
    logic [63:0] part_data;
    logic [3:0]  len_add;
    logic [16:0] len_sum;
    logic [15:0] len_nxt;
    logic        len_bad;

    logic        em_v;
    logic        em_eop;
    logic        em_perr;
    logic        em_err;

    assign is_start = (i_mii_rx_c == 8'h01) && (i_mii_rx_d[7:0] == 8'hFB);
    assign pre_ok   = (i_mii_rx_d == START_WORD);
    assign is_data  = (i_mii_rx_c == 8'h00);

    // Terminate decode: lowest control lane must be 0xFD with only idles above it.
    always_comb begin
        term_k    = 3'd0;
        part_keep = 8'h00;
        part_data = 64'h0;
        for (int j = 7; j >= 0; j--) begin
            if (i_mii_rx_c[j]) term_k = 3'(j);
        end
        term_ok = (i_mii_rx_c != 8'h00) && (i_mii_rx_d[8*term_k +: 8] == 8'hFD);
        for (int j = 0; j < 8; j++) begin
            if (3'(j) > term_k) begin
                if (!i_mii_rx_c[j] || (i_mii_rx_d[8*j +: 8] != 8'h07)) term_ok = 1'b0;
            end
            if (3'(j) < term_k) begin
                part_keep[j]        = 1'b1;
                part_data[8*j +: 8] = i_mii_rx_d[8*j +: 8];
            end
        end
    end

    always_comb begin
        len_add = is_data ? 4'd8 : {1'b0, term_k};
        len_sum = {1'b0, len_cnt} + {13'b0, len_add};
        len_nxt = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        len_bad = (len_cnt < LEN_MIN) || (len_cnt > LEN_MAX);
    end

    // What (if anything) the hold register emits on this accepted cycle.
    always_comb begin
        em_v    = 1'b0;
        em_eop  = 1'b0;
        em_perr = 1'b0;
        if (i_valid) begin
            if (eop_pend) begin
                em_v   = 1'b1;
                em_eop = 1'b1;
            end else if (state == DATA) begin
                if (is_data) begin
                    em_v = h_full;
                end else if (term_ok) begin
                    em_v   = (term_k == 3'd0) || h_full;
                    em_eop = (term_k == 3'd0);
                end else begin
                    em_v    = 1'b1;
                    em_eop  = 1'b1;
                    em_perr = 1'b1;
                end
            end
        end
        em_err = em_perr || len_bad;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state    <= IDLE;
            h_data   <= 64'h0;
            h_keep   <= 8'h00;
            h_full   <= 1'b0;
            sop_pend <= 1'b0;
            eop_pend <= 1'b0;
            len_cnt  <= 16'h0;
            o_valid  <= 1'b0;
            o_data   <= 64'h0;
            o_keep   <= 8'h00;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_err    <= 1'b0;
            o_len    <= 16'h0;
        end else begin
            o_valid <= em_v;
            o_data  <= (em_v && h_full) ? h_data : 64'h0;
            o_keep  <= (em_v && h_full) ? h_keep : 8'h00;
            o_sop   <= em_v && sop_pend;
            o_eop   <= em_v && em_eop;
            o_err   <= em_v && em_eop && em_err;
            o_len   <= (em_v && em_eop) ? len_cnt : 16'h0;
            if (em_v) sop_pend <= 1'b0;

            if (i_valid) begin
                if (eop_pend) begin
                    eop_pend <= 1'b0;
                    h_full   <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        if (is_start && pre_ok) begin
                            state    <= DATA;
                            len_cnt  <= 16'h0;
                            sop_pend <= 1'b1;
                            h_full   <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (is_data) begin
                            h_data  <= i_mii_rx_d;
                            h_keep  <= 8'hFF;
                            h_full  <= 1'b1;
                            len_cnt <= len_nxt;
                        end else if (term_ok) begin
                            state <= IDLE;
                            if (term_k == 3'd0) begin
                                h_full <= 1'b0;
                            end else begin
                                h_data   <= part_data;
                                h_keep   <= part_keep;
                                h_full   <= 1'b1;
                                eop_pend <= 1'b1;
                                len_cnt  <= len_nxt;
                            end
                        end else begin
                            state  <= IDLE;
                            h_full <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MII_RX_STATS_EN
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic        good_inc;
    logic        bad_frame;
    logic        bad_start;

    assign good_inc  = em_v && em_eop && !em_err;
    assign bad_frame = em_v && em_eop && em_err;
    // A pending bad frame and a rejected start word can land in the same cycle.
    assign bad_start = i_valid && !eop_pend && (state == IDLE) && is_start && !pre_ok
                     || i_valid && eop_pend && is_start && !pre_ok;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            good_cnt <= 32'h0;
            bad_cnt  <= 32'h0;
        end else begin
            good_cnt <= good_cnt + {31'b0, good_inc};
            bad_cnt  <= bad_cnt + {31'b0, bad_frame} + {31'b0, bad_start};
        end
    end

    assign o_good_cnt = good_cnt;
    assign o_bad_cnt  = bad_cnt;
`else
    assign o_good_cnt = 32'h0;
    assign o_bad_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_mii_rx_checker.sv
// Scoreboard bench for mii_rx_checker: directed frames push expected beats,
// a negedge monitor pops and compares every o_valid beat.
module tb_mii_rx_checker;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [63:0] i_mii_rx_d;
    logic [7:0]  i_mii_rx_c;
    logic        o_valid;
    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_sop;
    logic        o_eop;
    logic        o_err;
    logic [15:0] o_len;
    logic [31:0] o_good_cnt;
    logic [31:0] o_bad_cnt;

    mii_rx_checker dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_mii_rx_d (i_mii_rx_d),
        .i_mii_rx_c (i_mii_rx_c),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_keep     (o_keep),
        .o_sop      (o_sop),
        .o_eop      (o_eop),
        .o_err      (o_err),
        .o_len      (o_len),
        .o_good_cnt (o_good_cnt),
        .o_bad_cnt  (o_bad_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        sop;
        logic        eop;
        logic        err;
        logic [15:0] len;
    } beat_t;

    localparam logic [63:0] START_OK  = 64'hD5555555555555FB;
    localparam logic [63:0] START_BAD = 64'hD4555555555555FB;
    localparam logic [63:0] IDLE_W    = 64'h0707070707070707;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    m_good   = 0;
    int    m_bad    = 0;
    bit    stats_en;

    function automatic logic [7:0] fbyte(input int fid, input int i);
        return 8'((fid * 37 + i * 5 + 1) & 255);
    endfunction

    function automatic logic [63:0] fword(input int fid, input int j);
        logic [63:0] w;
        for (int l = 0; l < 8; l++) w[8*l +: 8] = fbyte(fid, j * 8 + l);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic s,
                        input logic e, input logic er, input logic [15:0] ln);
        beat_t b;
        b.data = d; b.keep = k; b.sop = s; b.eop = e; b.err = er; b.len = ln;
        sb.push_back(b);
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic v = 1'b1);
        @(posedge clk);
        #1;
        i_valid    = v;
        i_mii_rx_d = d;
        i_mii_rx_c = c;
    endtask

    // n = frame bytes; gap inserts an ignored (i_valid=0) start-like word before each word.
    task automatic send_frame(input int n, input int fid, input bit exp_err,
                              input bit idle_after, input bit gap);
        int          full = n / 8;
        int          k    = n % 8;
        logic [63:0] w;
        logic [7:0]  c;
        logic [7:0]  pk;
        w = 64'h0; c = 8'h00; pk = 8'h00;
        for (int l = 0; l < 8; l++) begin
            if (l < k) begin
                w[8*l +: 8] = fbyte(fid, full * 8 + l);
                pk[l] = 1'b1;
            end else if (l == k) begin
                w[8*l +: 8] = 8'hFD; c[l] = 1'b1;
            end else begin
                w[8*l +: 8] = 8'h07; c[l] = 1'b1;
            end
        end
        if (n == 0) push(64'h0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd0);
        for (int j = 0; j < full; j++)
            push(fword(fid, j), 8'hFF, j == 0, (k == 0) && (j == full - 1), exp_err, 16'(n));
        if (k != 0) push(w, pk, full == 0, 1'b1, exp_err, 16'(n));
        if (exp_err) m_bad++; else m_good++;

        drive(START_OK, 8'h01);
        for (int j = 0; j < full; j++) begin
            if (gap) drive(START_OK, 8'h01, 1'b0);
            drive(fword(fid, j), 8'h00);
        end
        if (gap) drive(START_OK, 8'h01, 1'b0);
        drive(w, c);
        if (idle_after) drive(IDLE_W, 8'hFF);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            drive(IDLE_W, 8'hFF);
            n++;
        end
        drive(IDLE_W, 8'hFF);
        @(negedge clk);
        check({name, "_drained"}, 64'(sb.size()), 64'd0);
        check({name, "_good_cnt"}, 64'(o_good_cnt), stats_en ? 64'(m_good) : 64'd0);
        check({name, "_bad_cnt"}, 64'(o_bad_cnt), stats_en ? 64'(m_bad) : 64'd0);
    endtask

    // Monitor: every presented beat must match the head of the scoreboard.
    initial begin
        beat_t       e;
        logic [63:0] mask;
        bit          ok;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat data=%0h keep=%0h sop=%0b eop=%0b expected=none",
                             o_data, o_keep, o_sop, o_eop);
                end else begin
                    e = sb.pop_front();
                    for (int l = 0; l < 8; l++) mask[8*l +: 8] = {8{e.keep[l]}};
                    ok = (((o_data ^ e.data) & mask) == 64'h0) && (o_keep == e.keep) &&
                         (o_sop == e.sop) && (o_eop == e.eop) &&
                         (!e.eop || ((o_err == e.err) && (o_len == e.len)));
                    if (!ok) begin
                        failures++;
                        $display("FAIL beat actual d=%0h k=%0h s=%0b e=%0b err=%0b len=%0d expected d=%0h k=%0h s=%0b e=%0b err=%0b len=%0d",
                                 o_data, o_keep, o_sop, o_eop, o_err, o_len,
                                 e.data, e.keep, e.sop, e.eop, e.err, e.len);
                    end
                end
            end
        end
    end

    initial begin
`ifdef MII_RX_STATS_EN
        stats_en = 1'b1;
`else
        stats_en = 1'b0;
`endif
        i_rst = 1'b1; i_valid = 1'b0; i_mii_rx_d = IDLE_W; i_mii_rx_c = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", o_data, 64'd0);
        check("rst_flags", {59'd0, o_sop, o_eop, o_err, 2'b0}, 64'd0);
        check("rst_len_keep", {40'd0, o_len, o_keep}, 64'd0);
        check("rst_cnt", {o_good_cnt, o_bad_cnt}, 64'd0);
        i_rst = 1'b0;

        send_frame(64, 1, 1'b0, 1'b1, 1'b0);
        drain("f64");
        send_frame(65, 2, 1'b0, 1'b1, 1'b0);
        drain("f65");
        send_frame(60, 3, 1'b1, 1'b1, 1'b0);
        drain("runt60");

        // Bad SFD: nothing emitted, counted as bad.
        drive(START_BAD, 8'h01);
        drive(fword(4, 0), 8'h00);
        drive(fword(4, 1), 8'h00);
        drive(64'h07070707070707FD, 8'hFF);
        m_bad++;
        drain("bad_sfd");

        // 0xFE in lane 3 of the third data word.
        push(fword(5, 0), 8'hFF, 1'b1, 1'b0, 1'b0, 16'd0);
        push(fword(5, 1), 8'hFF, 1'b0, 1'b1, 1'b1, 16'd16);
        m_bad++;
        drive(START_OK, 8'h01);
        drive(fword(5, 0), 8'h00);
        drive(fword(5, 1), 8'h00);
        drive({fword(5, 2)[63:32], 8'hFE, fword(5, 2)[23:0]}, 8'h08);
        drive(fword(5, 3), 8'h00);
        drive(fword(5, 4), 8'h00);
        drive(64'h07070707070707FD, 8'hFF);
        drain("proto_err");

        // Back-to-back: start word right after a lane-1 terminate.
        send_frame(65, 6, 1'b0, 1'b0, 1'b0);
        send_frame(64, 7, 1'b0, 1'b1, 1'b0);
        drain("b2b");

        send_frame(72, 8, 1'b0, 1'b1, 1'b1);
        drain("gaps");
        send_frame(0, 9, 1'b1, 1'b1, 1'b0);
        drain("empty");
        send_frame(1518, 10, 1'b0, 1'b1, 1'b0);
        drain("max1518");
        send_frame(1519, 11, 1'b1, 1'b1, 1'b0);
        drain("over1519");

        // Reset in the middle of a 1518-byte frame: 100 words sent, 99 beats out.
        for (int j = 0; j < 99; j++) push(fword(12, j), 8'hFF, j == 0, 1'b0, 1'b0, 16'd0);
        drive(START_OK, 8'h01);
        for (int j = 0; j < 100; j++) drive(fword(12, j), 8'h00);
        drive(fword(12, 100), 8'h00);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_eop", {62'd0, o_eop, o_sop}, 64'd0);
        check("midrst_data", o_data, 64'd0);
        check("midrst_len", {40'd0, o_len, o_keep}, 64'd0);
        check("midrst_cnt", {o_good_cnt, o_bad_cnt}, 64'd0);
        check("midrst_sb", 64'(sb.size()), 64'd0);
        i_rst = 1'b0;
        m_good = 0;
        m_bad  = 0;
        send_frame(64, 13, 1'b0, 1'b1, 1'b0);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
